// File: rtl/matmul_sequencer.sv
// matmul_sequencer: polls the MATMUL_Flag register, latches the operand bases
// and dimensions, computes C = A*B one element at a time from memory, writes
// C back and posts the done code into MATMUL_Flag.
// Optional feature: define MATMUL_SAT_EN to saturate each result to the
// signed DATA_WIDTH range; without it the result is the low DATA_WIDTH bits
// of the accumulator (two's-complement wrap).
// Memory port: a read address driven in cycle t returns data in mem_q during
// cycle t+1. Exactly one access (read or write) is presented every cycle.
module matmul_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy,
    output logic                  done
);

    localparam int ACC_W = 2 * DATA_WIDTH + 8;

    localparam logic [ADDR_WIDTH-1:0] REG_A    = ADDR_WIDTH'(12'h000);
    localparam logic [ADDR_WIDTH-1:0] REG_B    = ADDR_WIDTH'(12'h100);
    localparam logic [ADDR_WIDTH-1:0] REG_C    = ADDR_WIDTH'(12'h200);
    localparam logic [ADDR_WIDTH-1:0] REG_M    = ADDR_WIDTH'(12'h600);
    localparam logic [ADDR_WIDTH-1:0] REG_N    = ADDR_WIDTH'(12'h700);
    localparam logic [ADDR_WIDTH-1:0] REG_P    = ADDR_WIDTH'(12'h800);
    localparam logic [ADDR_WIDTH-1:0] REG_FLAG = ADDR_WIDTH'(12'hA00);

    localparam logic [DATA_WIDTH-1:0] FLAG_START = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] FLAG_DONE  = DATA_WIDTH'(2);

    typedef enum logic [2:0] {
        S_POLL, S_CHK, S_CFG, S_LDA, S_LDB, S_MAC, S_WR, S_FIN
    } state_t;

    state_t                  state_q;
    logic [2:0]              cfg_idx_q;
    logic                    cfg_cap_q;   // 0: issue read, 1: capture data
    logic [ADDR_WIDTH-1:0]   base_a_q, base_b_q, base_c_q;
    logic [DATA_WIDTH-1:0]   dim_m_q, dim_n_q, dim_p_q;
    logic [DATA_WIDTH-1:0]   i_q, j_q, k_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic signed [ACC_W-1:0] acc_q;

    logic [DATA_WIDTH-1:0]        i_inc, j_inc, k_inc;
    logic signed [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
    logic signed [ACC_W-1:0]      acc_d;
    logic [DATA_WIDTH-1:0]        result;
    logic [ADDR_WIDTH-1:0]        a_addr, b_addr, c_addr, cfg_addr;

    // Index increments, signed product and next accumulator value
    always_comb begin
        i_inc = i_q + DATA_WIDTH'(1);
        j_inc = j_q + DATA_WIDTH'(1);
        k_inc = k_q + DATA_WIDTH'(1);
        a_ext = (2*DATA_WIDTH)'($signed(a_q));
        b_ext = (2*DATA_WIDTH)'($signed(mem_q));
        prod  = a_ext * b_ext;
        acc_d = acc_q + ACC_W'(prod);
    end

    // Operand and result addresses, all modulo 2^ADDR_WIDTH
    always_comb begin
        a_addr = base_a_q + ADDR_WIDTH'(i_q * dim_n_q) + ADDR_WIDTH'(k_q);
        b_addr = base_b_q + ADDR_WIDTH'(k_q * dim_p_q) + ADDR_WIDTH'(j_q);
        c_addr = base_c_q + ADDR_WIDTH'(i_q * dim_p_q) + ADDR_WIDTH'(j_q);
        case (cfg_idx_q)
            3'd0:    cfg_addr = REG_A;
            3'd1:    cfg_addr = REG_B;
            3'd2:    cfg_addr = REG_C;
            3'd3:    cfg_addr = REG_M;
            3'd4:    cfg_addr = REG_N;
            default: cfg_addr = REG_P;
        endcase
    end

`ifdef MATMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (DATA_WIDTH - 1));

    // Clamp the accumulator into the signed element range
    always_comb begin
        if (acc_q > SAT_MAX)      result = SAT_MAX[DATA_WIDTH-1:0];
        else if (acc_q < SAT_MIN) result = SAT_MIN[DATA_WIDTH-1:0];
        else                      result = acc_q[DATA_WIDTH-1:0];
    end
`else
    // Two's-complement wrap: keep the low element-width bits
    always_comb begin
        result = acc_q[DATA_WIDTH-1:0];
    end
`endif

    // Sequencer FSM: poll, configure, fetch/MAC loop, write-back, done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_POLL;
            cfg_idx_q <= '0;
            cfg_cap_q <= 1'b0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            base_c_q  <= '0;
            dim_m_q   <= '0;
            dim_n_q   <= '0;
            dim_p_q   <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            a_q       <= '0;
            acc_q     <= '0;
        end else begin
            case (state_q)
                S_POLL: state_q <= S_CHK;
                S_CHK: begin
                    if (mem_q == FLAG_START) begin
                        state_q   <= S_CFG;
                        cfg_idx_q <= '0;
                        cfg_cap_q <= 1'b0;
                    end else begin
                        state_q <= S_POLL;
                    end
                end
                S_CFG: begin
                    if (!cfg_cap_q) begin
                        cfg_cap_q <= 1'b1;
                    end else begin
                        cfg_cap_q <= 1'b0;
                        case (cfg_idx_q)
                            3'd0:    base_a_q <= ADDR_WIDTH'(mem_q);
                            3'd1:    base_b_q <= ADDR_WIDTH'(mem_q);
                            3'd2:    base_c_q <= ADDR_WIDTH'(mem_q);
                            3'd3:    dim_m_q  <= mem_q;
                            3'd4:    dim_n_q  <= mem_q;
                            default: dim_p_q  <= mem_q;
                        endcase
                        if (cfg_idx_q == 3'd5) begin
                            i_q   <= '0;
                            j_q   <= '0;
                            k_q   <= '0;
                            acc_q <= '0;
                            // P is still on mem_q this cycle
                            if (dim_m_q == '0 || dim_n_q == '0 || mem_q == '0)
                                state_q <= S_FIN;
                            else
                                state_q <= S_LDA;
                        end else begin
                            cfg_idx_q <= cfg_idx_q + 3'd1;
                        end
                    end
                end
                S_LDA: state_q <= S_LDB;
                S_LDB: begin
                    a_q     <= mem_q;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    acc_q   <= acc_d;
                    k_q     <= k_inc;
                    state_q <= (k_inc == dim_n_q) ? S_WR : S_LDA;
                end
                S_WR: begin
                    acc_q <= '0;
                    k_q   <= '0;
                    if (j_inc == dim_p_q) begin
                        j_q     <= '0;
                        i_q     <= i_inc;
                        state_q <= (i_inc == dim_m_q) ? S_FIN : S_LDA;
                    end else begin
                        j_q     <= j_inc;
                        state_q <= S_LDA;
                    end
                end
                default: state_q <= S_POLL;  // S_FIN
            endcase
        end
    end

    // Moore decode of the memory port; reset forces the idle poll read
    always_comb begin
        mem_addr  = REG_FLAG;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_CFG: mem_addr = cfg_addr;
                S_LDA: mem_addr = a_addr;
                S_LDB: mem_addr = b_addr;
                S_MAC: mem_addr = b_addr;
                S_WR: begin
                    mem_addr  = c_addr;
                    mem_wdata = result;
                    mem_we    = 1'b1;
                end
                S_FIN: begin
                    mem_wdata = FLAG_DONE;
                    mem_we    = 1'b1;
                end
                default: mem_addr = REG_FLAG;
            endcase
        end
    end

    // Status: busy outside the poll loop, done during the flag write
    always_comb begin
        busy = !rst && (state_q != S_POLL) && (state_q != S_CHK);
        done = !rst && (state_q == S_FIN);
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed tests for matmul_sequencer against a small
// word-addressed memory model with one-cycle read latency.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_q;
    logic        mem_we, busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matmul_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_q     (mem_q),
        .busy      (busy),
        .done      (done)
    );

    // Memory model: bench pokes and DUT writes share one process
    logic [31:0] mem [0:8191];
    logic        poke_en   = 1'b0;
    logic [12:0] poke_addr = '0;
    logic [31:0] poke_data = '0;
    int c_wr       = 0;
    int flag_wr    = 0;
    int wr_in_rst  = 0;
    int other_addr = 0;

    always @(posedge clk) begin
        mem_q <= mem[mem_addr[12:0]];
        if (poke_en) mem[poke_addr] = poke_data;
        if (mem_we) begin
            mem[mem_addr[12:0]] = mem_wdata;
            if (mem_addr == 32'h0000_0A00) flag_wr++;
            else c_wr++;
            if (rst) wr_in_rst++;
        end
        if (mem_addr != 32'h0000_0A00) other_addr++;
    end

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a[12:0];
        poke_data = d;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    task automatic setup_cfg(input int m, input int n, input int p);
        poke(32'h000, 32'h1000);
        poke(32'h100, 32'h1010);
        poke(32'h200, 32'h1020);
        poke(32'h600, m);
        poke(32'h700, n);
        poke(32'h800, p);
    endtask

    task automatic load_2x2();
        poke(32'h1000, 1); poke(32'h1001, 2); poke(32'h1002, 3); poke(32'h1003, 4);
        poke(32'h1010, 5); poke(32'h1011, 6); poke(32'h1012, 7); poke(32'h1013, 8);
        for (int q = 0; q < 4; q++) poke(32'h1020 + q, 32'hDEAD_BEEF);
    endtask

    // Waits for busy to rise and then for done; t_done < 0 means timeout
    task automatic wait_done(output int t_start, output int t_done, output int gaps);
        t_start = -1;
        t_done  = -1;
        gaps    = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (busy && t_start < 0) t_start = n;
            if (t_start >= 0 && !busy) gaps++;
            if (done) begin
                t_done = n;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        poke(32'hA00, 0);
        @(negedge clk);
        if (mem_addr !== 32'h0000_0A00) begin bad++; $display("FAIL rst_addr: got %0h want a00", mem_addr); end
        total++;
        if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %0b want 0", mem_we); end
        total++;
        if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %0h want 0", mem_wdata); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
        total++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int ts, td, gaps, c0, f0, idle_busy;
        logic [31:0] exp_c [4];
        exp_c = '{32'd19, 32'd22, 32'd43, 32'd50};
        setup_cfg(2, 2, 2);
        load_2x2();
        c0 = c_wr;
        f0 = flag_wr;
        poke(32'hA00, 1);
        wait_done(ts, td, gaps);
        if (td < 0) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
        total++;
        if (td - ts != 40) begin bad++; $display("FAIL basic_latency: got %0d want 40", td - ts); end
        total++;
        if (gaps != 0) begin bad++; $display("FAIL basic_busy: got %0d low cycles want 0", gaps); end
        total++;
        for (int q = 0; q < 4; q++) begin
            if (mem[32'h1020 + q] !== exp_c[q]) begin
                bad++; $display("FAIL basic_c%0d: got %0d want %0d", q, mem[32'h1020 + q], exp_c[q]);
            end
            total++;
        end
        if (mem[32'hA00] !== 32'd2) begin bad++; $display("FAIL basic_flag: got %0h want 2", mem[32'hA00]); end
        total++;
        if (c_wr - c0 != 4) begin bad++; $display("FAIL basic_cwrites: got %0d want 4", c_wr - c0); end
        total++;
        if (flag_wr - f0 != 1) begin bad++; $display("FAIL basic_flagwrites: got %0d want 1", flag_wr - f0); end
        total++;
        idle_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) idle_busy++;
        end
        if (idle_busy != 0) begin bad++; $display("FAIL basic_norestart: got %0d busy cycles want 0", idle_busy); end
        total++;
    endtask

    task automatic test_zero_dim();
        int ts, td, gaps, c0;
        setup_cfg(0, 3, 3);
        c0 = c_wr;
        poke(32'hA00, 1);
        wait_done(ts, td, gaps);
        if (td < 0 || td - ts != 12) begin bad++; $display("FAIL zero_latency: got %0d want 12", td - ts); end
        total++;
        if (c_wr - c0 != 0) begin bad++; $display("FAIL zero_cwrites: got %0d want 0", c_wr - c0); end
        total++;
        if (mem[32'hA00] !== 32'd2) begin bad++; $display("FAIL zero_flag: got %0h want 2", mem[32'hA00]); end
        total++;
    endtask

    task automatic test_signed();
        int ts, td, gaps;
        setup_cfg(1, 1, 1);
        poke(32'h1000, 32'hFFFF_FFFD);
        poke(32'h1010, 32'd7);
        poke(32'h1020, 32'hDEAD_BEEF);
        poke(32'hA00, 1);
        wait_done(ts, td, gaps);
        if (td < 0) begin bad++; $display("FAIL signed_timeout: got no done want done"); end
        total++;
        if (mem[32'h1020] !== 32'hFFFF_FFEB) begin bad++; $display("FAIL signed_c: got %0h want ffffffeb", mem[32'h1020]); end
        total++;
    endtask

    task automatic test_overflow();
        int ts, td, gaps;
        logic [31:0] exp_v;
`ifdef MATMUL_SAT_EN
        exp_v = 32'h7FFF_FFFF;
`else
        exp_v = 32'hFFFF_FFFE;
`endif
        setup_cfg(1, 1, 1);
        poke(32'h1000, 32'h7FFF_FFFF);
        poke(32'h1010, 32'd2);
        poke(32'h1020, 32'hDEAD_BEEF);
        poke(32'hA00, 1);
        wait_done(ts, td, gaps);
        if (td < 0) begin bad++; $display("FAIL ovf_timeout: got no done want done"); end
        total++;
        if (mem[32'h1020] !== exp_v) begin bad++; $display("FAIL ovf_c: got %0h want %0h", mem[32'h1020], exp_v); end
        total++;
    endtask

    task automatic test_reset_mid();
        int ts, td, gaps, c0, c1, r0, n;
        logic [31:0] exp_c [4];
        exp_c = '{32'd19, 32'd22, 32'd43, 32'd50};
        setup_cfg(2, 2, 2);
        load_2x2();
        c0 = c_wr;
        poke(32'hA00, 1);
        n = 0;
        while (c_wr - c0 < 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (c_wr - c0 != 1) begin bad++; $display("FAIL mid_firstwrite: got %0d writes want 1", c_wr - c0); end
        total++;
        repeat (3) @(negedge clk);
        r0  = wr_in_rst;
        rst = 1'b1;
        @(negedge clk);
        if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_we: got %0b want 0", mem_we); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL mid_done: got %0b want 0", done); end
        total++;
        rst = 1'b0;
        c1  = c_wr;
        wait_done(ts, td, gaps);
        if (wr_in_rst - r0 != 0) begin bad++; $display("FAIL mid_rstwrites: got %0d want 0", wr_in_rst - r0); end
        total++;
        if (td < 0 || td - ts != 40) begin bad++; $display("FAIL mid_latency: got %0d want 40", td - ts); end
        total++;
        for (int q = 0; q < 4; q++) begin
            if (mem[32'h1020 + q] !== exp_c[q]) begin
                bad++; $display("FAIL mid_c%0d: got %0d want %0d", q, mem[32'h1020 + q], exp_c[q]);
            end
            total++;
        end
        if (c_wr - c1 != 4) begin bad++; $display("FAIL mid_cwrites: got %0d want 4", c_wr - c1); end
        total++;
        if (mem[32'hA00] !== 32'd2) begin bad++; $display("FAIL mid_flag: got %0h want 2", mem[32'hA00]); end
        total++;
    endtask

    task automatic test_ignored_flag();
        int o0, w0, busy_cnt;
        poke(32'hA00, 3);
        o0 = other_addr;
        w0 = c_wr + flag_wr;
        busy_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        if (busy_cnt != 0) begin bad++; $display("FAIL ign_busy: got %0d busy cycles want 0", busy_cnt); end
        total++;
        if (c_wr + flag_wr - w0 != 0) begin bad++; $display("FAIL ign_writes: got %0d want 0", c_wr + flag_wr - w0); end
        total++;
        if (other_addr - o0 != 0) begin bad++; $display("FAIL ign_addr: got %0d non-flag reads want 0", other_addr - o0); end
        total++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_dim();
        test_signed();
        test_overflow();
        test_reset_mid();
        test_ignored_flag();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
